// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Brief    : Instruction fetch stage for the pipelined 16-bit MIPS core.
//             Owns the PC, drives the word address to a combinational-read
//             instruction memory and registers the returned word into IF/ID.
//             Handles stall, flush and branch redirect from later stages.
//  Options  : FETCH_HALT_EN - when defined, fetching an instruction whose
//             opcode equals HALT_OPCODE parks fetch in a HALTED state until
//             reset or a branch redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_WORD    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc1,
    output logic        ifid_valid,
    output logic        halted
);

    localparam logic [15:0] c_PC_STEP = 16'd1;

    logic [15:0] r_pc;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc1;
    logic        r_ifid_valid;
    logic [15:0] w_pc_next;

    // Sequential increment wraps modulo 2^16 by construction.
    assign w_pc_next = r_pc + c_PC_STEP;

`ifdef FETCH_HALT_EN
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    logic   w_is_halt;

    assign w_is_halt = (imem_data[15:12] == HALT_OPCODE);
`endif

    // PC, IF/ID register and fetch state; priority rst > br_taken > halted > flush > stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc1   <= 16'h0000;
            r_ifid_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            r_state      <= ST_RUN;
`endif
        end else if (br_taken) begin
            // Redirect squashes whatever was fetched on the wrong path.
            r_pc         <= br_target;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc1   <= 16'h0000;
            r_ifid_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            r_state      <= ST_RUN;
`endif
        end
`ifdef FETCH_HALT_EN
        else if (r_state == ST_HALTED) begin
            // Parked: PC holds, stall/flush are irrelevant, IF/ID stays empty.
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc1   <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end
`endif
        else if (flush) begin
            // Bubble into IF/ID; PC is kept so the current address is refetched.
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc1   <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end else if (!stall) begin
            r_pc         <= w_pc_next;
            r_ifid_instr <= imem_data;
            r_ifid_pc1   <= w_pc_next;
            r_ifid_valid <= 1'b1;
`ifdef FETCH_HALT_EN
            // The halt word itself is delivered as a valid instruction.
            if (w_is_halt) begin
                r_state <= ST_HALTED;
            end
`endif
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc1   = r_ifid_pc1;
    assign ifid_valid = r_ifid_valid;

`ifdef FETCH_HALT_EN
    assign halted = (r_state == ST_HALTED);
`else
    // No halt support: the opcode parameter has no function in this build.
    logic w_unused_halt_opcode;
    assign w_unused_halt_opcode = ^HALT_OPCODE;
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc1;
    logic        ifid_valid;
    logic        halted;

    logic [15:0] mem [64];

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_HALT_EN
    localparam bit HALT_BUILD = 1'b1;
`else
    localparam bit HALT_BUILD = 1'b0;
`endif

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .pc         (pc),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory, 64 words aliased over the address space.
    assign imem_data = mem[imem_addr[5:0]];

    typedef struct {
        logic        st;
        logic        fl;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_pc1;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                           input logic [15:0] e_pc1, input logic e_valid, input logic e_halted);
        chk({tag, ".pc"},        pc,                   e_pc);
        chk({tag, ".imem_addr"}, imem_addr,            e_pc);
        chk({tag, ".instr"},     ifid_instr,           e_instr);
        chk({tag, ".pc1"},       ifid_pc1,             e_pc1);
        chk({tag, ".valid"},     {15'd0, ifid_valid},  {15'd0, e_valid});
        chk({tag, ".halted"},    {15'd0, halted},      {15'd0, e_halted});
    endtask

    task automatic step(input logic r, input logic st, input logic fl, input logic br, input logic [15:0] tgt);
        @(negedge clk);
        rst = r; stall = st; flush = fl; br_taken = br; br_target = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[40] = 16'hF123;

        //          st    fl    br    tgt       pc        instr     pc1       v     h
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1001, 16'h0002, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'h1002, 16'h0003, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1003, 16'h0004, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h1005, 16'h0006, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0007, 16'h1006, 16'h0007, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h1007, 16'h0008, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0014, 16'h0014, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0015, 16'h1014, 16'h0015, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1003, 16'h0004, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h103F, 16'h0000, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 16'h0028, 16'h0028, 16'h0000, 16'h0000, 1'b0, 1'b0};
        // Opcode F: delivered as a valid word; halts only in the halt-enabled build.
        vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0029, 16'hF123, 16'h0029, 1'b1, HALT_BUILD};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 21; i++) begin
            step(1'b0, vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].tgt);
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_pc1, vecs[i].e_valid, vecs[i].e_halted);
        end

`ifdef FETCH_HALT_EN
        // Parked: PC holds, IF/ID empties, stall/flush do nothing.
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("halt_hold", 16'h0029, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk_all("halt_stfl", 16'h0029, 16'h0000, 16'h0000, 1'b0, 1'b1);
        // Exit via branch, even with stall asserted.
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk_all("halt_exit", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("halt_run", 16'h0001, 16'h1000, 16'h0001, 1'b1, 1'b0);
        // A stalled or flushed halt word must not halt.
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0028);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk_all("halt_stalled", 16'h0028, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk_all("halt_flushed", 16'h0028, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // Squashed by a simultaneous branch: no halt.
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
        chk_all("halt_squash", 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0028);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("halt_again", 16'h0029, 16'hF123, 16'h0029, 1'b1, 1'b1);
        // Reset while halted.
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk_all("halt_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
`else
        // Opcode F does not stop fetch in this build.
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("f_no_halt", 16'h002A, 16'h1029, 16'h002A, 1'b1, 1'b0);
`endif

        // Reset mid-operation with stall and flush asserted.
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("pre_rst", 16'h0011, 16'h1010, 16'h0011, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0033);
        chk_all("mid_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("post_rst", 16'h0001, 16'h1000, 16'h0001, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
